// File: rtl/mcu_frame_send_pkg.sv
// Shared MCU-link frame definitions: frame delimiters, FSM state and frame phase types.
package mcu_frame_send_pkg;

  localparam logic [7:0] FRAME_HEAD = 8'h68;
  localparam logic [7:0] FRAME_TAIL = 8'h16;

  // Width of the per-byte timeout counter; large enough for the default 20000-cycle budget.
  localparam int TMO_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_RD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_HEAD,
    PH_CTRL,
    PH_LEN,
    PH_PAYLOAD,
    PH_CS,
    PH_TAIL
  } phase_t;

endpackage

// File: rtl/mcu_frame_send.sv
// Response frame builder: 0x68, ctrl, len, payload[len], checksum, 0x16 over the UART byte TX.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for send_req; ctrl/len latched on acceptance
//   ST_SEL   | choose next byte by phase; payload bytes issue a buffer read
//   ST_RD    | payload byte returns from the buffer into tx_data
//   ST_START | one-cycle tx_start pulse, per-byte timeout reloaded
//   ST_WAIT  | waiting for tx_done rising edge or timeout
//   ST_DONE  | one-cycle send_done pulse after the tail byte
module mcu_frame_send
  import mcu_frame_send_pkg::*;
#(
  parameter logic [7:0]  START_CODE = FRAME_HEAD,
  parameter logic [7:0]  END_CODE   = FRAME_TAIL,
  parameter int unsigned TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_req,
  input  logic [7:0] send_ctrl,
  input  logic [7:0] send_len,
  output logic [7:0] pl_addr,
  output logic       pl_rd_en,
  input  logic [7:0] pl_data,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_done,
  output logic       busy,
  output logic       send_done,
  output logic       send_err
);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT);

  state_t           state, state_nxt;
  phase_t           phase;
  logic [7:0]       ctrl_q, len_q, idx, cs;
  logic [TMO_W-1:0] tmo_cnt;
  logic             done_d1, done_d2;
  logic             done_edge, tmo_hit, last_payload;

  assign done_edge    = done_d1 & ~done_d2;
  // Down-counter reaching zero is the expiry; a zero TIMEOUT disables expiry entirely.
  assign tmo_hit      = (TIMEOUT != 0) && (tmo_cnt == '0);
  assign last_payload = (idx == len_q - 8'd1);

  // Two-stage synchroniser for tx_done; preset high so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_d1 <= 1'b1;
      done_d2 <= 1'b1;
    end else begin
      done_d1 <= tx_done;
      done_d2 <= done_d1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; a tx_done edge takes priority over a coincident timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (send_req) state_nxt = ST_SEL;
      ST_SEL:   state_nxt = (phase == PH_PAYLOAD) ? ST_RD : ST_START;
      ST_RD:    state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (done_edge)    state_nxt = (phase == PH_TAIL) ? ST_DONE : ST_SEL;
        else if (tmo_hit) state_nxt = ST_IDLE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode; busy drops in the same cycle as the send_done/send_err pulse.
  always_comb begin
    pl_addr   = 8'h00;
    pl_rd_en  = 1'b0;
    tx_start  = 1'b0;
    send_done = 1'b0;
    send_err  = 1'b0;
    case (state)
      ST_SEL: begin
        if (phase == PH_PAYLOAD) begin
          pl_addr  = idx;
          pl_rd_en = 1'b1;
        end
      end
      ST_START: tx_start  = 1'b1;
      ST_WAIT:  send_err  = !done_edge && tmo_hit;
      ST_DONE:  send_done = 1'b1;
      default: ;
    endcase
    busy = (state != ST_IDLE) && (state != ST_DONE) && !send_err;
  end

  // Frame datapath: byte selection, checksum accumulation, phase/index advance, timeout timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase   <= PH_HEAD;
      ctrl_q  <= 8'h00;
      len_q   <= 8'h00;
      idx     <= 8'h00;
      cs      <= 8'h00;
      tx_data <= 8'h00;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (send_req) begin
            ctrl_q <= send_ctrl;
            len_q  <= send_len;
            idx    <= 8'h00;
            cs     <= 8'h00;
            phase  <= PH_HEAD;
          end
        end
        ST_SEL: begin
          case (phase)
            PH_HEAD: tx_data <= START_CODE;
            PH_CTRL: begin
              tx_data <= ctrl_q;
              cs      <= cs + ctrl_q;
            end
            PH_LEN: begin
              tx_data <= len_q;
              cs      <= cs + len_q;
            end
            PH_CS:   tx_data <= cs;
            PH_TAIL: tx_data <= END_CODE;
            default: ;
          endcase
        end
        ST_RD: begin
          tx_data <= pl_data;
          cs      <= cs + pl_data;
        end
        ST_START: tmo_cnt <= TMO_LOAD;
        ST_WAIT: begin
          if (done_edge) begin
            case (phase)
              PH_HEAD: phase <= PH_CTRL;
              PH_CTRL: phase <= PH_LEN;
              PH_LEN:  phase <= (len_q == 8'h00) ? PH_CS : PH_PAYLOAD;
              PH_PAYLOAD: begin
                if (last_payload) phase <= PH_CS;
                else              idx   <= idx + 8'd1;
              end
              PH_CS:   phase <= PH_TAIL;
              default: ;
            endcase
          end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
